// File: rtl/rom_read_arbiter_pkg.sv
// ============================================================================
//  Module   : rom_arb_pkg
//  Purpose  : Shared types and constants for the ROM read arbiter slice.
//             - FSM state encoding
//             - default address/data widths
//             - port index constants
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_arb_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 20;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage : rom_arb_pkg

`default_nettype wire

// File: rtl/rom_read_arbiter_if.sv
// ============================================================================
//  Module   : rom_arb_if
//  Purpose  : Bundles the two requester ports and the ROM pins of the arbiter.
//  Ports    : req0/1_*  request handshake (valid/ready + address)
//             rsp0/1_*  response handshake (valid/ready + data)
//             rom_*     ROM load/address out, registered ROM data in
//  Modports : slave  - the arbiter
//             master - the requesters and ROM around it
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rom_arb_if
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_ready;

  logic              rom_load;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data_out;

  modport slave (
    input  req0_valid, req0_addr, rsp0_ready,
    input  req1_valid, req1_addr, rsp1_ready,
    input  rom_data_out,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output rom_load, rom_address
  );

  modport master (
    output req0_valid, req0_addr, rsp0_ready,
    output req1_valid, req1_addr, rsp1_ready,
    output rom_data_out,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  rom_load, rom_address
  );

endinterface : rom_arb_if

`default_nettype wire

// File: rtl/rom_read_arbiter_rr_arb2.sv
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Combinational two-way round-robin grant. On a tie the port that
//             did not win last time is granted; a lone requester always wins.
//  Ports    : req0, req1   request inputs
//             last_grant   index of the previous winner (owned by the FSM)
//             enable       grants are only produced while enabled
//             grant0/1     one-hot (or zero) grant outputs
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import rom_arb_pkg::*;
(
  input  wire logic req0,
  input  wire logic req1,
  input  wire logic last_grant,
  input  wire logic enable,
  output logic      grant0,
  output logic      grant1
);

  assign grant0 = enable & req0 & (~req1 | (last_grant == P1));
  assign grant1 = enable & req1 & (~req0 | (last_grant == P0));

endmodule : rr_arb2

`default_nettype wire

// File: rtl/rom_read_arbiter.sv
// ============================================================================
//  Module   : rom_read_arbiter
//  Purpose  : Shares one synchronous ROM between an instruction-fetch port (0)
//             and a data/table port (1). One read is outstanding at a time:
//             IDLE (grant) -> ISSUE (rom_load pulse) -> CAPT (capture ROM
//             data) -> RESP (hold response until the owner takes it).
//  Ports    : clk    rising-edge system clock
//             rst_n  asynchronous active-low reset
//             bus    rom_arb_if slave modport (requests, responses, ROM pins)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  wire logic clk,
  input  wire logic rst_n,
  rom_arb_if.slave  bus
);

  state_t            r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_rom_load;
  logic [ADDR_W-1:0] r_rom_address;
  logic              r_rsp0_valid;
  logic [DATA_W-1:0] r_rsp0_data;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp1_data;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_owner_ready;

  assign w_idle = (r_state == IDLE);

  rr_arb2 u_rr_arb2 (
    .req0       (bus.req0_valid),
    .req1       (bus.req1_valid),
    .last_grant (r_last_grant),
    .enable     (w_idle),
    .grant0     (w_grant0),
    .grant1     (w_grant1)
  );

  assign w_owner_ready = (r_owner == P0) ? bus.rsp0_ready : bus.rsp1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_owner       <= P0;
      r_last_grant  <= P1;   // makes port 0 win the first tie
      r_rom_load    <= 1'b0;
      r_rom_address <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp0_data   <= '0;
      r_rsp1_valid  <= 1'b0;
      r_rsp1_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0) begin
            r_rom_address <= bus.req0_addr;
            r_rom_load    <= 1'b1;
            r_owner       <= P0;
            r_last_grant  <= P0;
            r_state       <= ISSUE;
          end else if (w_grant1) begin
            r_rom_address <= bus.req1_addr;
            r_rom_load    <= 1'b1;
            r_owner       <= P1;
            r_last_grant  <= P1;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          // ROM samples load/address on this edge; the address is left in
          // place afterwards since rom_load alone gates the ROM.
          r_rom_load <= 1'b0;
          r_state    <= CAPT;
        end
        CAPT: begin
          if (r_owner == P0) begin
            r_rsp0_data  <= bus.rom_data_out;
            r_rsp0_valid <= 1'b1;
          end else begin
            r_rsp1_data  <= bus.rom_data_out;
            r_rsp1_valid <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          // Data registers are not cleared; only valid drops.
          if (w_owner_ready) begin
            if (r_owner == P0) begin
              r_rsp0_valid <= 1'b0;
            end else begin
              r_rsp1_valid <= 1'b0;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = w_grant0;
  assign bus.req1_ready  = w_grant1;
  assign bus.rsp0_valid  = r_rsp0_valid;
  assign bus.rsp0_data   = r_rsp0_data;
  assign bus.rsp1_valid  = r_rsp1_valid;
  assign bus.rsp1_data   = r_rsp1_data;
  assign bus.rom_load    = r_rom_load;
  assign bus.rom_address = r_rom_address;

endmodule : rom_read_arbiter

`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
// ============================================================================
//  Module   : tb_rom_read_arbiter
//  Purpose  : Self-checking bench for rom_read_arbiter with a synchronous ROM
//             model and an accept/response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_read_arbiter;
  import rom_arb_pkg::*;

  localparam int AW = 20;
  localparam int DW = 20;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  rom_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents: two pinned words, everything else a simple hash.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if (a == 20'h00005) return 20'h0ABCD;
    if (a == 20'hFFFFF) return 20'hFFFFF;
    return (a * 20'd13) ^ 20'h5A5A5;
  endfunction

  // Synchronous ROM: registered output, one edge after load.
  initial bus.rom_data_out = '0;
  always @(posedge clk) begin
    if (bus.rom_load) bus.rom_data_out <= rom_word(bus.rom_address);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard entry: {port, data}
  logic [DW:0]       sb[$];
  int                g_port[$];
  int                g_cyc[$];
  logic [AW-1:0]     acc_addr;
  logic              prev_load = 1'b0;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst_n) begin
      if (bus.req0_ready || bus.req1_ready)
        check("one_grant", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back({1'b0, rom_word(bus.req0_addr)});
        g_port.push_back(0); g_cyc.push_back(cyc); acc_addr = bus.req0_addr;
      end else if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back({1'b1, rom_word(bus.req1_addr)});
        g_port.push_back(1); g_cyc.push_back(cyc); acc_addr = bus.req1_addr;
      end
      if (bus.rom_load) begin
        check("load_pulse", {31'd0, prev_load}, 32'd0);
        check("load_addr", {12'd0, bus.rom_address}, {12'd0, acc_addr});
      end
      if (bus.rsp0_valid || bus.rsp1_valid)
        check("rsp_excl", {31'd0, bus.rsp0_valid & bus.rsp1_valid}, 32'd0);
      if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
        if (sb.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_port", {31'd0, bus.rsp1_valid}, {31'd0, e[DW]});
          check("rsp_data", {12'd0, bus.rsp1_valid ? bus.rsp1_data : bus.rsp0_data},
                {12'd0, e[DW-1:0]});
        end
      end
    end
    prev_load = bus.rom_load;
  end

  task automatic drop_all();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.rsp0_ready = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drop_all();
    repeat (2) @(posedge clk);
    #1;
    sb.delete(); g_port.delete(); g_cyc.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int p, input string tag);
    bit got = 1'b0;
    #1;
    for (int i = 0; i < 50 && !got; i++) begin
      if ((p == 0) ? bus.req0_ready : bus.req1_ready) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !bus.rsp0_valid && !bus.rsp1_valid && !bus.rom_load) done = 1'b1;
    end
    if (!done) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    int guard;
    rst_n = 1'b0;
    drop_all();

    // ---- reset values
    #12;
    check("rst_load",  {31'd0, bus.rom_load}, 32'd0);
    check("rst_addr",  {12'd0, bus.rom_address}, 32'd0);
    check("rst_v0",    {31'd0, bus.rsp0_valid}, 32'd0);
    check("rst_v1",    {31'd0, bus.rsp1_valid}, 32'd0);
    check("rst_d0",    {12'd0, bus.rsp0_data}, 32'd0);
    check("rst_d1",    {12'd0, bus.rsp1_data}, 32'd0);
    do_reset();

    // ---- port 0 single read at 0x00005
    bus.req0_valid = 1'b1; bus.req0_addr = 20'h00005; bus.rsp0_ready = 1'b1;
    #1;
    check("t1_ready", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    check("t1_load",  {31'd0, bus.rom_load}, 32'd1);
    check("t1_addr",  {12'd0, bus.rom_address}, 32'h00005);
    @(posedge clk); #1;
    check("t1_load_off", {31'd0, bus.rom_load}, 32'd0);
    check("t1_v0_early", {31'd0, bus.rsp0_valid}, 32'd0);
    @(posedge clk); #1;
    check("t1_v0",   {31'd0, bus.rsp0_valid}, 32'd1);
    check("t1_d0",   {12'd0, bus.rsp0_data}, 32'h0ABCD);
    check("t1_v1",   {31'd0, bus.rsp1_valid}, 32'd0);
    wait_idle("t1");

    // ---- both ports continuously: alternation and 4-cycle throughput
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 20'h00010; bus.rsp0_ready = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_addr = 20'h00020; bus.rsp1_ready = 1'b1;
    n = 0; guard = 0;
    while (n < 4 && guard < 40) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) n++;
      @(posedge clk); #1;
      guard++;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("t2_ngrant", n, 32'd4);
    wait_idle("t2");
    check("t2_log_size", g_port.size(), 32'd4);
    for (int i = 0; i < g_port.size() && i < 4; i++) begin
      check("t2_order", g_port[i], i % 2);
      if (i > 0) check("t2_spacing", g_cyc[i] - g_cyc[i-1], 32'd4);
    end

    // ---- port 1 response backpressure while port 0 waits
    bus.rsp1_ready = 1'b0; bus.rsp0_ready = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_addr = 20'h00030;
    wait_grant(1, "t3_g1");
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 20'h00040;
    #1;
    check("t3_r0_issue", {31'd0, bus.req0_ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("t3_v1_hold", {31'd0, bus.rsp1_valid}, 32'd1);
      check("t3_d1_hold", {12'd0, bus.rsp1_data}, {12'd0, rom_word(20'h00030)});
      check("t3_r0_block", {31'd0, bus.req0_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp1_ready = 1'b1;
    #1;
    check("t3_r0_resp", {31'd0, bus.req0_ready}, 32'd0);
    @(posedge clk); #1;
    check("t3_r0_idle", {31'd0, bus.req0_ready}, 32'd1);
    check("t3_v1_drop", {31'd0, bus.rsp1_valid}, 32'd0);
    check("t3_d1_keep", {12'd0, bus.rsp1_data}, {12'd0, rom_word(20'h00030)});
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_idle("t3");

    // ---- reset during ISSUE of a port 0 read at 0xFFFFF
    bus.req0_valid = 1'b1; bus.req0_addr = 20'hFFFFF; bus.rsp0_ready = 1'b1;
    wait_grant(0, "t4_g0");
    @(posedge clk); #1;
    check("t4_issue_load", {31'd0, bus.rom_load}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_load", {31'd0, bus.rom_load}, 32'd0);
    check("t4_rst_v0",   {31'd0, bus.rsp0_valid}, 32'd0);
    check("t4_rst_v1",   {31'd0, bus.rsp1_valid}, 32'd0);
    sb.delete();
    bus.req1_valid = 1'b1; bus.req1_addr = 20'h00020; bus.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("t4_tie_r0", {31'd0, bus.req0_ready}, 32'd1);
    check("t4_tie_r1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_grant(1, "t4_g1");
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_idle("t4");

    // ---- port 1 alone at the top address
    bus.req1_valid = 1'b1; bus.req1_addr = 20'hFFFFF; bus.rsp1_ready = 1'b1;
    wait_grant(1, "t5_g1");
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    check("t5_load", {31'd0, bus.rom_load}, 32'd1);
    check("t5_addr", {12'd0, bus.rom_address}, 32'h000FFFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_v1", {31'd0, bus.rsp1_valid}, 32'd1);
    check("t5_d1", {12'd0, bus.rsp1_data}, 32'h000FFFFF);
    check("t5_v0", {31'd0, bus.rsp0_valid}, 32'd0);
    wait_idle("t5");

    // ---- three port 0 reads back to back, then port 1 joins
    bus.req0_valid = 1'b1; bus.req0_addr = 20'h00100; bus.rsp0_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(0, "t6_g0");
      @(posedge clk); #1;
      bus.req0_addr = 20'h00101 + 20'(k);
    end
    bus.req1_valid = 1'b1; bus.req1_addr = 20'h00200; bus.rsp1_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 50 && n == 0; i++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) n = 1;
      else @(posedge clk);
    end
    check("t6_seen", n, 32'd1);
    check("t6_r1", {31'd0, bus.req1_ready}, 32'd1);
    check("t6_r0", {31'd0, bus.req0_ready}, 32'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_idle("t6");
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rom_read_arbiter

`default_nettype wire

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares the single synchronous ROM between two requesters: port 0 (instruction fetch) and port 1 (data/table lookup).
- Arbitrates round-robin and drives the ROM load/address pins. Captures the ROM's registered data and returns it to the winning port with a valid/ready response handshake.
- Sits between the ROM and the datapath. One ROM transaction is outstanding at a time.

Parameters:
ADDR_W, 20, ROM address width (ROM depth is 2^ADDR_W words)
DATA_W, 20, ROM word width

Ports:
clk  in  1  system clock; every register is rising-edge
rst_n  in  1  asynchronous, active-low reset
req0_valid  in  1  port 0 requests a read
req0_addr  in  ADDR_W  port 0 read address; held stable while req0_valid is high
req0_ready  out  1  port 0 request accepted this cycle
rsp0_valid  out  1  port 0 read data valid
rsp0_data  out  DATA_W  port 0 read data
rsp0_ready  in  1  port 0 consumes the response
req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_ready: same as port 0, for port 1
rom_load  out  1  ROM read enable, registered
rom_address  out  ADDR_W  ROM address, registered
rom_data_out  in  DATA_W  ROM registered read data

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state=IDLE, rom_load=0, rom_address=0.
  - rsp0/1_valid=0, rsp0/1_data=0.
  - owner=0, last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE:
  - grant0 = req0_valid & (!req1_valid | last_grant==1).
  - grant1 = req1_valid & (!req0_valid | last_grant==0).
  - reqN_ready = grantN, combinational, and only ever asserted in IDLE.
  - On an accept edge E0: rom_address<=reqN_addr, rom_load<=1, owner<=N, last_grant<=N, state->ISSUE.
- ISSUE:
  - rom_load is high for exactly this one cycle. The ROM samples at edge E1.
  - At E1: rom_load<=0, state->CAPT.
- CAPT:
  - rom_data_out is now valid.
  - At E2: rsp<owner>_data<=rom_data_out, rsp<owner>_valid<=1, state->RESP.
- RESP:
  - rsp<owner>_valid and rsp<owner>_data are held until rsp<owner>_ready=1.
  - On the edge where ready is high: valid<=0 and state->IDLE.
  - rsp_data keeps its last value after valid drops.
- Timing:
  - Latency is accept edge to rsp_valid high = 2 clock edges.
  - Peak throughput is one read per 4 cycles, when rsp_ready is held high.
- Requests outside IDLE: reqN_ready=0 and the requester keeps waiting. No queueing; new requests are never dropped.
- Both ports valid in IDLE: strict alternation. The port that did not win last time is granted.
- Single active port: granted every IDLE visit, regardless of last_grant.
- rom_address is not cleared after a read; only rom_load gates the ROM.
- The non-owner's rsp_valid stays 0 throughout a transaction.
- Reset asserted mid-transaction:
  - The in-flight read is abandoned and no response is generated.
  - rom_load drops immediately (asynchronously).
  - ROM contents are unaffected.
- Address wrap: none. The full ADDR_W range passes through unchanged, including all-ones.

Decomposition:
- Shared package rom_arb_pkg holds:
  - the state enum {IDLE, ISSUE, CAPT, RESP};
  - ADDR_W and DATA_W defaults;
  - the port-index constants P0=0, P1=1.
- One sub-module: rr_arb2.
  - Purely combinational two-way round-robin grant.
  - Inputs: req0, req1, last_grant, enable.
  - Outputs: grant0, grant1.
  - Owned and updated by the FSM.

Test Plan:
- Reset, then port 0 only, addr 0x00005, mem[5]=0x0ABCD, rsp0_ready=1:
  - req0_ready high in the first IDLE cycle.
  - rom_load high for exactly one cycle with rom_address=0x00005.
  - rsp0_valid high 2 edges after accept with rsp0_data=0x0ABCD.
  - rsp1_valid stays 0.
- Both ports valid continuously, addr0=0x00010, addr1=0x00020, readies high:
  - grant order is P0, P1, P0, P1.
  - rom_address alternates 0x00010/0x00020.
  - each response arrives on the correct port only.
  - one read every 4 cycles.
- Port 1 response backpressure (rsp1_ready low for 5 cycles) with port 0 requesting:
  - rsp1_valid and rsp1_data are held stable.
  - req0_ready stays 0 until rsp1_ready rises.
  - port 0 is then granted in the next IDLE.
- rst_n pulled low during ISSUE of a port 0 read at 0xFFFFF:
  - rom_load=0 and all rsp_valid=0 immediately.
  - after release, port 0 is granted first again on a tie.
- Boundary address 0xFFFFF with mem[0xFFFFF]=0xFFFFF on port 1 alone:
  - rsp1_data=0xFFFFF.
  - rom_address=0xFFFFF during ISSUE.
- Port 0 alone issues 3 back-to-back reads, then port 1 joins in IDLE:
  - port 1 wins the next grant, because last_grant=0.
